lfsr_gen: RTL
=============

Name: lfsr_gen

Overview:
- Parametrised LFSR generator with selectable Fibonacci or Galois structure, runtime seed load, step enable and zero-seed protection.
- Built-in period measurement that reports the cycle length each time the sequence returns to its seed.
- Used as a pseudo-random source and as a self-checking sequence generator in the lab/test designs.
- Replaces hand-built fixed-width 4-bit set/reset-flop generators.

Parameters:
- N, 4, register width (3..32).
- MODE, 0, 0 = Fibonacci, 1 = Galois.
- TAPS, 4'b1001, N-bit tap mask (meaning depends on MODE, see Behaviour).
- DEFAULT_SEED, 1, N-bit reset/fallback seed; must be nonzero.
- CW, 16, width of the step counter and the period register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  advance one step this cycle.
- load  in  1  load seed this cycle; has priority over en.
- seed  in  N  seed value sampled when load=1.
- q  out  N  current LFSR state.
- sout  out  1  serial output, equal to q[N-1].
- wrap  out  1  one-cycle pulse: the state has returned to the active seed.
- period  out  CW  steps between the last two returns to seed (or seed-to-first-return).
- period_valid  out  1  high once period holds a measured value; cleared by load.
- seed_err  out  1  one-cycle pulse: load was issued with seed==0.

Behaviour:
- Reset (rst=0, async):
  - q = DEFAULT_SEED; internal seed_reg = DEFAULT_SEED.
  - cnt = 0, period = 0; wrap, period_valid and seed_err = 0.
- Next state, Fibonacci (MODE=0):
  - fb = XOR over q[i] for all i where TAPS[i]=1.
  - next = {q[N-2:0], fb}.
- Next state, Galois (MODE=1):
  - next = {q[N-2:0],1'b0} XOR (q[N-1] ? TAPS : 0).
  - TAPS[0] must be 1.
- Priority each clock edge: load > en > hold.
- load=1, seed!=0:
  - q <= seed; seed_reg <= seed.
  - cnt <= 0; period_valid <= 0; wrap <= 0.
- load=1, seed==0:
  - Same as above, but DEFAULT_SEED is used in place of seed.
  - seed_err <= 1 for one cycle.
- en=1, load=0:
  - q <= next.
  - If next==seed_reg: wrap <= 1, period <= cnt+1, period_valid <= 1, cnt <= 0.
  - Otherwise: wrap <= 0, cnt <= cnt+1 (saturating at 2^CW-1).
- en=0, load=0:
  - q, cnt and period hold.
  - wrap <= 0 and seed_err <= 0; both are single-cycle pulses only.
- Latency:
  - q, wrap and period all update on the same edge that takes the step.
  - No combinational path from any input to any output.
- All-zero lockup:
  - Unreachable by construction: reset and load never produce 0.
  - If q==0 is ever observed with en=1, q <= DEFAULT_SEED on the next step (defensive recovery), and wrap is not asserted.
- Saturation: when cnt is saturated and the seed is hit, period = 2^CW-1. This is the marker for "period exceeds counter".
- Reset mid-sequence: all state returns immediately to reset values, and the seed reverts to DEFAULT_SEED.

Decomposition:
- Shared package lfsr_pkg:
  - Mode constants LFSR_FIB=0, LFSR_GAL=1.
  - Standard maximal tap masks for N=3..8, as Fibonacci and Galois localparams, e.g. FIB_TAPS_4=4'b1001, GAL_TAPS_4=4'b0011.
- One natural sub-module: lfsr_next.
  - Purely combinational: N, MODE, TAPS, q -> next.
  - Lets the period/control logic stay separate and allows the next-state function to be unit-tested alone.

Test Plan:
- Reset, N=4, MODE=0, TAPS=1001: hold rst=0 for 25 ns, then release. Required:
  - q=0001, period_valid=0.
  - With en=1, q steps 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, 0001.
  - wrap pulses on the 15th step, period=15, period_valid=1.
- Galois, N=4, MODE=1, TAPS=0011, seed 0001, en=1. Required:
  - q steps 0010, 0100, 1000, 0011, 0110, 1100, 1011, 0101, 1010, 0111, 1110, 1111, 1101, 1001, 0001.
  - wrap on step 15, period=15.
- Load seed=1010 in Fibonacci mode, then en=1. Required:
  - Next q = 0101.
  - wrap after 15 steps when q returns to 1010; period=15.
- load=1 with seed=0000. Required:
  - q=0001 (DEFAULT_SEED), seed_err pulses for exactly one cycle, period_valid=0.
- Simultaneous load=1 and en=1 with seed=1100. Required:
  - q=1100 with no step applied, cnt=0.
  - en toggled 1/0 thereafter: q advances only on en=1 cycles, wrap never exceeds 1 cycle.
- Assert rst=0 mid-sequence (e.g. q=0110, cnt=9). Required:
  - q=0001, period=0, wrap=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: structure selectors and maximal-length tap masks.
// A FIB mask feeds bit 0 and must include bit N-1. A GAL mask holds the low polynomial terms.
package lfsr_pkg;

    localparam int LFSR_FIB = 0;
    localparam int LFSR_GAL = 1;

    localparam logic [2:0] FIB_TAPS_3 = 3'b101;
    localparam logic [3:0] FIB_TAPS_4 = 4'b1001;
    localparam logic [4:0] FIB_TAPS_5 = 5'b10010;
    localparam logic [5:0] FIB_TAPS_6 = 6'b100001;
    localparam logic [6:0] FIB_TAPS_7 = 7'b1000001;
    localparam logic [7:0] FIB_TAPS_8 = 8'b10001110;

    localparam logic [2:0] GAL_TAPS_3 = 3'b011;
    localparam logic [3:0] GAL_TAPS_4 = 4'b0011;
    localparam logic [4:0] GAL_TAPS_5 = 5'b00101;
    localparam logic [5:0] GAL_TAPS_6 = 6'b000011;
    localparam logic [6:0] GAL_TAPS_7 = 7'b0000011;
    localparam logic [7:0] GAL_TAPS_8 = 8'b00011101;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state function, selectable Fibonacci or Galois structure.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int             N    = 4,
    parameter int             MODE = LFSR_FIB,
    parameter logic [N-1:0]   TAPS = 'b1001
) (
    input  logic [N-1:0] q,
    output logic [N-1:0] next
);

    generate
        if (MODE == LFSR_GAL) begin : g_gal
            assign next = {q[N-2:0], 1'b0} ^ (q[N-1] ? TAPS : '0);
        end else begin : g_fib
            logic fb;
            assign fb   = ^(q & TAPS);
            assign next = {q[N-2:0], fb};
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with seed load, zero-seed protection and period measurement
// (steps between consecutive returns to the active seed).
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int             N            = 4,
    parameter int             MODE         = LFSR_FIB,
    parameter logic [N-1:0]   TAPS         = 'b1001,
    parameter logic [N-1:0]   DEFAULT_SEED = 'd1,
    parameter int             CW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [N-1:0]  seed,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          wrap,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          seed_err
);

    logic [N-1:0]  seed_reg;
    logic [N-1:0]  nxt;
    logic [N-1:0]  ld_val;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          seed_zero;

    lfsr_next #(.N(N), .MODE(MODE), .TAPS(TAPS)) u_next (
        .q    (q),
        .next (nxt)
    );

    assign seed_zero = (seed == '0);
    assign ld_val    = seed_zero ? DEFAULT_SEED : seed;
    // Saturating increment: all-ones marks "period exceeds counter".
    assign cnt_inc   = (&cnt) ? cnt : cnt + CW'(1);
    assign sout      = q[N-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q            <= DEFAULT_SEED;
            seed_reg     <= DEFAULT_SEED;
            cnt          <= '0;
            period       <= '0;
            wrap         <= 1'b0;
            period_valid <= 1'b0;
            seed_err     <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            seed_err <= 1'b0;
            if (load) begin
                q            <= ld_val;
                seed_reg     <= ld_val;
                cnt          <= '0;
                period_valid <= 1'b0;
                seed_err     <= seed_zero;
            end else if (en) begin
                if (q == '0) begin
                    // Lockup recovery; never counts as a return to seed.
                    q   <= DEFAULT_SEED;
                    cnt <= cnt_inc;
                end else begin
                    q <= nxt;
                    if (nxt == seed_reg) begin
                        wrap         <= 1'b1;
                        period       <= cnt_inc;
                        period_valid <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule
